// File: rtl/shifter_operand2.sv
// ARM operand-2 shifter feeding the ALU B input and the shifter carry-out.
// Register form: LSL/LSR/ASR/ROR by shift_amt. Immediate form: imm8 ROR 2*rot.
// Default build is iterative (one bit position per clock, latency N+1).
// Define SHIFTER_FAST_EN to use a single-cycle barrel shifter with the
// same outputs; done then always follows start by one cycle.
module shifter_operand2 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             imm_mode,
    input  logic [1:0]       shift_type,
    input  logic [7:0]       shift_amt,
    input  logic [WIDTH-1:0] rm,
    input  logic [7:0]       imm8,
    input  logic [3:0]       rot,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             sh_co
);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    localparam logic [1:0] T_LSL = 2'b00;
    localparam logic [1:0] T_LSR = 2'b01;
    localparam logic [1:0] T_ASR = 2'b10;
    localparam logic [1:0] T_ROR = 2'b11;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] work_q, work_d, work_nxt;
    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_q, carry_d, carry_nxt;
    logic             sh_co_q, sh_co_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [5:0]       cnt_q, cnt_d;
    logic [1:0]       type_q, type_d;

    logic [WIDTH-1:0] op_start;
    logic [1:0]       type_start;
    logic [5:0]       n_start;
    logic             co_zero;

`ifdef SHIFTER_FAST_EN
    // Closed-form equivalent of n single-bit steps; returns {carry, value}.
    function automatic logic [WIDTH:0] barrel(input logic [WIDTH-1:0] v,
                                              input logic [1:0] t,
                                              input logic [5:0] n,
                                              input logic ci);
        logic [2*WIDTH-1:0] ext;
        logic [WIDTH-1:0]   res;
        logic               co;
        ext = '0;
        res = v;
        co  = ci;
        if (n != 6'd0) begin
            case (t)
                T_LSL: begin
                    ext = {{WIDTH{1'b0}}, v} << n;
                    res = ext[WIDTH-1:0];
                    co  = ext[WIDTH];
                end
                T_LSR: begin
                    ext = {v, {WIDTH{1'b0}}} >> n;
                    res = ext[2*WIDTH-1:WIDTH];
                    co  = ext[WIDTH-1];
                end
                T_ASR: begin
                    ext = $signed({v, {WIDTH{1'b0}}}) >>> n;
                    res = ext[2*WIDTH-1:WIDTH];
                    co  = ext[WIDTH-1];
                end
                default: begin
                    ext = {v, v} >> n;
                    res = ext[WIDTH-1:0];
                    co  = res[WIDTH-1];
                end
            endcase
        end
        return {co, res};
    endfunction
`endif

    // Decode the operand, effective iteration count and zero-count carry at start.
    always_comb begin
        op_start   = imm_mode ? WIDTH'(imm8) : rm;
        type_start = imm_mode ? T_ROR : shift_type;
        co_zero    = cin;
        n_start    = 6'd0;
        if (imm_mode) begin
            n_start = {1'b0, rot, 1'b0};
        end else begin
            case (shift_type)
                T_LSL, T_LSR: n_start = (shift_amt > 8'd33) ? 6'd33 : shift_amt[5:0];
                T_ASR:        n_start = (shift_amt > 8'd32) ? 6'd32 : shift_amt[5:0];
                default: begin
                    n_start = {1'b0, shift_amt[4:0]};
                    // ROR by a nonzero multiple of 32 leaves rm intact but sets C to bit 31.
                    if (shift_amt != 8'd0 && shift_amt[4:0] == 5'd0) co_zero = rm[WIDTH-1];
                end
            endcase
        end
    end

    // One single-bit step of the working register; the carry takes the bit moved out.
    always_comb begin
        work_nxt  = work_q;
        carry_nxt = carry_q;
        case (type_q)
            T_LSL: begin
                carry_nxt = work_q[WIDTH-1];
                work_nxt  = {work_q[WIDTH-2:0], 1'b0};
            end
            T_LSR: begin
                carry_nxt = work_q[0];
                work_nxt  = {1'b0, work_q[WIDTH-1:1]};
            end
            T_ASR: begin
                carry_nxt = work_q[0];
                work_nxt  = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
            end
            default: begin
                carry_nxt = work_q[0];
                work_nxt  = {work_q[0], work_q[WIDTH-1:1]};
            end
        endcase
    end

    // Next-state and registered-output logic for the start/busy/done handshake.
    always_comb begin
        state_d  = state_q;
        work_d   = work_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        type_d   = type_q;
        result_d = result_q;
        sh_co_d  = sh_co_q;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
`ifdef SHIFTER_FAST_EN
                    {sh_co_d, result_d} = barrel(op_start, type_start, n_start, co_zero);
                    state_d = S_DONE;
                    busy_d  = 1'b1;
                    done_d  = 1'b1;
`else
                    work_d  = op_start;
                    carry_d = cin;
                    type_d  = type_start;
                    cnt_d   = n_start;
                    busy_d  = 1'b1;
                    if (n_start == 6'd0) begin
                        result_d = op_start;
                        sh_co_d  = co_zero;
                        state_d  = S_DONE;
                        done_d   = 1'b1;
                    end else begin
                        state_d = S_SHIFT;
                    end
`endif
                end
            end
            S_SHIFT: begin
                busy_d  = 1'b1;
                work_d  = work_nxt;
                carry_d = carry_nxt;
                cnt_d   = cnt_q - 6'd1;
                if (cnt_q == 6'd1) begin
                    result_d = work_nxt;
                    sh_co_d  = carry_nxt;
                    state_d  = S_DONE;
                    done_d   = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            work_q   <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= 6'd0;
            type_q   <= T_LSL;
            result_q <= '0;
            sh_co_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            work_q   <= work_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            type_q   <= type_d;
            result_q <= result_d;
            sh_co_q  <= sh_co_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign sh_co  = sh_co_q;

endmodule

// File: tb/tb_shifter_operand2.sv
// Scoreboard bench for shifter_operand2: the driver pushes expected results
// from an ARM-semantics reference model; a monitor checks each done pulse.
module tb_shifter_operand2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        imm_mode = 1'b0;
    logic [1:0]  shift_type = 2'b00;
    logic [7:0]  shift_amt = 8'd0;
    logic [31:0] rm = 32'd0;
    logic [7:0]  imm8 = 8'd0;
    logic [3:0]  rot = 4'd0;
    logic        cin = 1'b0;
    logic        busy, done, sh_co;
    logic [31:0] result;

    shifter_operand2 #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .imm_mode(imm_mode),
        .shift_type(shift_type), .shift_amt(shift_amt), .rm(rm), .imm8(imm8),
        .rot(rot), .cin(cin), .busy(busy), .done(done), .result(result), .sh_co(sh_co)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic        co;
        int          lat;
        int          start_cyc;
    } exp_t;

    exp_t        q[$];
    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;
    logic [31:0] last_res;
    logic        last_co;

`ifdef SHIFTER_FAST_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // ARM operand-2 semantics written directly from the shift rules.
    function automatic void ref_model(input logic im, input logic [1:0] t, input int a,
                                      input logic [31:0] r, input logic [7:0] i8,
                                      input logic [3:0] ro, input logic c,
                                      output logic [31:0] res, output logic co, output int n);
        int s;
        logic [31:0] iv;
        if (im) begin
            s  = 2 * int'(ro);
            n  = s;
            iv = {24'd0, i8};
            if (s == 0) begin res = iv; co = c; end
            else begin res = (iv >> s) | (iv << (32 - s)); co = res[31]; end
        end else begin
            case (t)
                2'b00: begin
                    n = (a > 33) ? 33 : a;
                    if (a == 0)      begin res = r;       co = c;          end
                    else if (a < 32) begin res = r << a;  co = r[32 - a];  end
                    else if (a == 32) begin res = 32'd0;  co = r[0];       end
                    else             begin res = 32'd0;   co = 1'b0;       end
                end
                2'b01: begin
                    n = (a > 33) ? 33 : a;
                    if (a == 0)      begin res = r;       co = c;          end
                    else if (a < 32) begin res = r >> a;  co = r[a - 1];   end
                    else if (a == 32) begin res = 32'd0;  co = r[31];      end
                    else             begin res = 32'd0;   co = 1'b0;       end
                end
                2'b10: begin
                    n = (a > 32) ? 32 : a;
                    if (a == 0)      begin res = r;                 co = c;        end
                    else if (a < 32) begin res = $signed(r) >>> a;  co = r[a - 1]; end
                    else             begin res = {32{r[31]}};       co = r[31];    end
                end
                default: begin
                    s = a % 32;
                    n = s;
                    if (a == 0)      begin res = r; co = c;     end
                    else if (s == 0) begin res = r; co = r[31]; end
                    else begin res = (r >> s) | (r << (32 - s)); co = res[31]; end
                end
            endcase
        end
    endfunction

    task automatic issue(input logic im, input logic [1:0] t, input int a, input logic [31:0] r,
                         input logic [7:0] i8, input logic [3:0] ro, input logic c, input bit push);
        exp_t e;
        int   n;
        @(negedge clk);
        imm_mode = im; shift_type = t; shift_amt = 8'(a); rm = r; imm8 = i8; rot = ro; cin = c;
        start = 1'b1;
        if (push) begin
            ref_model(im, t, a, r, i8, ro, c, e.res, e.co, n);
            e.lat       = FAST ? 1 : n + 1;
            e.start_cyc = cyc + 1;
            q.push_back(e);
            last_res = e.res;
            last_co  = e.co;
        end
        @(negedge clk);
        start = 1'b0;
        rm = $urandom; imm8 = 8'($urandom); cin = 1'($urandom); shift_amt = 8'($urandom);
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 100 && q.size() != 0; k++) @(posedge clk);
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL timeout: done not seen, %0d pending expected 1 completion", q.size());
            q.delete();
        end
        @(negedge clk);
    endtask

    task automatic run(input logic im, input logic [1:0] t, input int a, input logic [31:0] r,
                       input logic [7:0] i8, input logic [3:0] ro, input logic c);
        issue(im, t, a, r, i8, ro, c, 1'b1);
        wait_idle();
    endtask

    // Monitor: compares every done pulse against the head of the scoreboard.
    initial begin
        logic prev_done;
        exp_t e;
        prev_done = 1'b0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (prev_done && done) check("done_width", 32'(done), 32'd0);
            if (done && !reset) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=1 expected no completion (cycle %0d)", cyc);
                end else begin
                    e = q.pop_front();
                    check("result", result, e.res);
                    check("sh_co", 32'(sh_co), 32'(e.co));
                    check("latency", 32'(cyc - e.start_cyc + 1), 32'(e.lat));
                    check("busy_at_done", 32'(busy), 32'd1);
                end
            end
            prev_done = done;
        end
    end

    initial begin
        int a;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_sh_co", 32'(sh_co), 32'd0);

        run(1'b0, 2'b00, 4,  32'h0000_000F, 8'h00, 4'd0, 1'b1);
        run(1'b0, 2'b01, 32, 32'h8000_0001, 8'h00, 4'd0, 1'b0);
        run(1'b0, 2'b01, 40, 32'h8000_0001, 8'h00, 4'd0, 1'b1);
        run(1'b0, 2'b10, 40, 32'h8000_0000, 8'h00, 4'd0, 1'b0);
        run(1'b0, 2'b10, 0,  32'h8000_0000, 8'h00, 4'd0, 1'b0);
        run(1'b0, 2'b11, 1,  32'h0000_0001, 8'h00, 4'd0, 1'b0);
        run(1'b0, 2'b11, 64, 32'h0000_0001, 8'h00, 4'd0, 1'b1);
        run(1'b0, 2'b00, 32, 32'h0000_0001, 8'h00, 4'd0, 1'b0);
        run(1'b0, 2'b00, 33, 32'hFFFF_FFFF, 8'h00, 4'd0, 1'b1);
        run(1'b1, 2'b00, 0,  32'h0000_0000, 8'hFF, 4'd4, 1'b0);
        run(1'b1, 2'b00, 0,  32'h0000_0000, 8'hFF, 4'd0, 1'b1);

        // Second start while busy must be ignored and not disturb the first result.
        issue(1'b0, 2'b00, 10, 32'h0000_0003, 8'h00, 4'd0, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        issue(1'b0, 2'b01, 1, 32'hFFFF_FFFF, 8'h00, 4'd0, 1'b1, 1'b0);
        wait_idle();
        repeat (3) @(negedge clk);
        check("hold_result", result, last_res);
        check("hold_sh_co", 32'(sh_co), 32'(last_co));

        // Reset three cycles into a long operation aborts it.
        issue(1'b0, 2'b00, 20, 32'h1234_5678, 8'h00, 4'd0, 1'b1, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_result", result, 32'd0);
        q.delete();
        @(negedge clk);
        reset = 1'b0;
        run(1'b0, 2'b00, 20, 32'h1234_5678, 8'h00, 4'd0, 1'b1);

        for (int i = 0; i < 150; i++) begin
            a = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 40));
            run(1'($urandom), 2'($urandom), a, $urandom, 8'($urandom), 4'($urandom), 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
